// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forwarding selects,
// controller states and the shadow-scoreboard slot layout.
package exe_hazard_ctrl_pkg;

    // Slot rd field is sized for the widest register index supported; narrower
    // indices are zero-extended on entry and on comparison.
    localparam int unsigned SB_RD_W  = 8;
    localparam int unsigned SB_NSLOT = 3;
    localparam int unsigned SLOT_EX  = 0;
    localparam int unsigned SLOT_MEM = 1;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_ALU  = 2'd1,
        FWD_MEM  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               wr;
        logic               load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

    // A slot supplies a source when it holds a live writer of that non-zero register.
    function automatic logic slot_match(sb_slot_t slot, logic [SB_RD_W-1:0] src, logic used);
        return used && slot.valid && slot.wr && (slot.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Three-slot shadow of the EX/MEM/WB destination registers. Shifts one slot
// per advance, can drop the incoming entry, and holds everything when not
// advancing. Reports which of the two decode sources hit EX and MEM.
module hz_scoreboard
    import exe_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    input  logic               invalidate,
    input  sb_slot_t           dec_slot,
    input  logic [SB_RD_W-1:0] src_a,
    input  logic [SB_RD_W-1:0] src_b,
    input  logic               use_a,
    input  logic               use_b,
    output logic               ex_valid,
    output logic               ex_load,
    output logic [1:0]         ex_match,
    output logic [1:0]         mem_match
);

    sb_slot_t slot_q [SB_NSLOT];

    // Slot pipeline: decode -> EX -> MEM -> WB on advance, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SB_NSLOT; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
        end else if (advance) begin
            for (int unsigned i = SB_NSLOT - 1; i > 0; i--) begin
                slot_q[i] <= slot_q[i-1];
            end
            slot_q[SLOT_EX] <= invalidate ? SLOT_EMPTY : dec_slot;
        end
    end

    // Source hit vectors, bit 0 = source A, bit 1 = source B.
    always_comb begin
        ex_valid     = slot_q[SLOT_EX].valid;
        ex_load      = slot_q[SLOT_EX].valid && slot_q[SLOT_EX].load;
        ex_match[0]  = slot_match(slot_q[SLOT_EX],  src_a, use_a);
        ex_match[1]  = slot_match(slot_q[SLOT_EX],  src_b, use_b);
        mem_match[0] = slot_match(slot_q[SLOT_MEM], src_a, use_a);
        mem_match[1] = slot_match(slot_q[SLOT_MEM], src_b, use_b);
    end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard controller: load-use bubbles, branch/jump flushes,
// data-memory wait freezes, registered forwarding selects and event counters.
module exe_hazard_ctrl
    import exe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [NREG_W-1:0] dec_rs1,
    input  logic [NREG_W-1:0] dec_rs2,
    input  logic [NREG_W-1:0] dec_rd,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              dec_wr,
    input  logic              dec_load,
    input  logic              exe_branch,
    input  logic              exe_jump,
    input  logic              br_true,
    input  logic              mem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [XLEN-1:0]   stall_cnt,
    output logic [XLEN-1:0]   flush_cnt
);

    sb_slot_t           dec_slot;
    logic [SB_RD_W-1:0] src_a;
    logic [SB_RD_W-1:0] src_b;
    logic               ex_valid;
    logic               ex_load;
    logic [1:0]         ex_match;
    logic [1:0]         mem_match;

    logic               redirect;
    logic               load_use;
    logic               stall;
    fwd_sel_t           sel_a;
    fwd_sel_t           sel_b;
    fwd_sel_t           fwd_a_q;
    fwd_sel_t           fwd_b_q;
    hz_state_t          state_q;
    hz_state_t          state_d;
    hz_state_t          ret_q;
    hz_state_t          ret_d;
    logic [XLEN-1:0]    stall_cnt_q;
    logic [XLEN-1:0]    flush_cnt_q;

    // Decode entry and source indices widened to the scoreboard format.
    always_comb begin
        dec_slot       = SLOT_EMPTY;
        dec_slot.valid = dec_valid;
        dec_slot.rd    = SB_RD_W'(dec_rd);
        dec_slot.wr    = dec_wr;
        dec_slot.load  = dec_load;
        src_a          = SB_RD_W'(dec_rs1);
        src_b          = SB_RD_W'(dec_rs2);
    end

    hz_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (!mem_busy),
        .invalidate (redirect || load_use),
        .dec_slot   (dec_slot),
        .src_a      (src_a),
        .src_b      (src_b),
        .use_a      (dec_use_rs1),
        .use_b      (dec_use_rs2),
        .ex_valid   (ex_valid),
        .ex_load    (ex_load),
        .ex_match   (ex_match),
        .mem_match  (mem_match)
    );

    // Hazard arbitration: memory wait beats redirect beats load-use; reset forces all low.
    always_comb begin
        redirect = 1'b0;
        load_use = 1'b0;
        stall    = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                stall = 1'b1;
            end else if (ex_valid && (exe_jump || (exe_branch && br_true))) begin
                redirect = 1'b1;
            end else if (ex_load && (|ex_match)) begin
                load_use = 1'b1;
                stall    = 1'b1;
            end
        end
    end

    // Forwarding selects computed at decode; EX hit wins over MEM hit.
    always_comb begin
        sel_a = ex_match[0] ? FWD_ALU : (mem_match[0] ? FWD_MEM : FWD_NONE);
        sel_b = ex_match[1] ? FWD_ALU : (mem_match[1] ? FWD_MEM : FWD_NONE);
    end

    // Selects travel into EX with their instruction; squashed entries carry none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else if (!mem_busy) begin
            fwd_a_q <= (redirect || load_use) ? FWD_NONE : sel_a;
            fwd_b_q <= (redirect || load_use) ? FWD_NONE : sel_b;
        end
    end

    // Controller state and the state to resume after a memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    // Next state. Stall/flush outputs come from slot contents rather than the
    // state so that a load-use frozen under MEM_WAIT is still caught on resume.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        if (mem_busy) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
        end else begin
            case (state_q)
                RUN:      state_d = load_use ? LU_STALL : RUN;
                LU_STALL: state_d = RUN;
                MEM_WAIT: state_d = load_use ? LU_STALL : ret_q;
                default:  state_d = RUN;
            endcase
        end
    end

    // Saturating stall and redirect event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = load_use;
    assign flush_id  = redirect;
    assign flush_ex  = redirect;
    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-level model of the in-flight pipeline.
module tb_exe_hazard_ctrl;

    localparam int XLEN   = 32;
    localparam int NREG_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dec_valid;
    logic [NREG_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic              dec_use_rs1, dec_use_rs2, dec_wr, dec_load;
    logic              exe_branch, exe_jump, br_true, mem_busy;
    logic              stall_if, stall_id, bubble_ex, flush_id, flush_ex;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [XLEN-1:0]   stall_cnt, flush_cnt;
    logic [4:0]        ctrl;

    exe_hazard_ctrl #(.XLEN(XLEN), .NREG_W(NREG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr(dec_wr), .dec_load(dec_load),
        .exe_branch(exe_branch), .exe_jump(exe_jump), .br_true(br_true), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {stall_if, stall_id, bubble_ex, flush_id, flush_ex}
    assign ctrl = {stall_if, stall_id, bubble_ex, flush_id, flush_ex};

    int total = 0;
    int bad   = 0;

    // Model: instructions in flight, index = age (0 = in EX, 1 = in MEM, 2 = in WB).
    typedef struct { bit v; int rd; bit wr; bit ld; } ins_t;
    ins_t        m_pipe [3];
    int          m_fa, m_fb;
    logic [31:0] m_scnt, m_fcnt;
    bit          m_redir, m_lu;
    logic [4:0]  e_ctrl;

    function automatic ins_t mk_ins(bit v, int rd, bit wr, bit ld);
        ins_t r;
        r.v = v; r.rd = rd; r.wr = wr; r.ld = ld;
        return r;
    endfunction

    // Select = 1 + age of the youngest in-flight writer among the two nearest, else 0.
    function automatic int src_sel(int s, bit used);
        if (!used || s == 0) return 0;
        for (int age = 0; age < 2; age++)
            if (m_pipe[age].v && m_pipe[age].wr && m_pipe[age].rd == s) return age + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = mk_ins(0, 0, 0, 0);
        m_fa = 0; m_fb = 0; m_scnt = '0; m_fcnt = '0;
    endtask

    task automatic eval_model();
        int sa, sb;
        sa = src_sel(int'(dec_rs1), dec_use_rs1);
        sb = src_sel(int'(dec_rs2), dec_use_rs2);
        m_redir = m_pipe[0].v && (exe_jump || (exe_branch && br_true));
        m_lu    = m_pipe[0].v && m_pipe[0].ld && (sa == 1 || sb == 1);
        if (mem_busy)     e_ctrl = 5'b11000;
        else if (m_redir) e_ctrl = 5'b00011;
        else if (m_lu)    e_ctrl = 5'b11100;
        else              e_ctrl = 5'b00000;
    endtask

    // Advance the model across one rising edge, leaving time at edge + 1.
    task automatic clock_model();
        int sa, sb;
        bit squash, busy, redir, st;
        ins_t nxt;
        eval_model();
        sa = src_sel(int'(dec_rs1), dec_use_rs1);
        sb = src_sel(int'(dec_rs2), dec_use_rs2);
        squash = m_redir || m_lu;
        busy   = mem_busy;
        redir  = m_redir;
        st     = e_ctrl[3];
        nxt    = squash ? mk_ins(0, 0, 0, 0) : mk_ins(dec_valid, int'(dec_rd), dec_wr, dec_load);
        @(posedge clk);
        if (!busy) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = nxt;
            m_fa = squash ? 0 : sa;
            m_fb = squash ? 0 : sb;
            if (redir && m_fcnt != '1) m_fcnt = m_fcnt + 32'd1;
        end
        if (st && m_scnt != '1) m_scnt = m_scnt + 32'd1;
        #1;
    endtask

    task automatic set_dec(bit v, int rs1, int rs2, int rd, bit u1, bit u2, bit wr, bit ld);
        dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr = wr; dec_load = ld;
    endtask

    task automatic idle_inputs();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        exe_branch = 0; exe_jump = 0; br_true = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_busy = 1'b1; exe_jump = 1'b1;
        rst_n = 1'b0;
        #2;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", ctrl); end
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin bad++; $display("FAIL reset_sel got=%b exp=0000", {fwd_a_sel, fwd_b_sel}); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL reset_release_ctrl got=%b exp=00000", ctrl); end
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_dec(1, 1, 2, 5, 1, 1, 1, 0);                  // add x5,x1,x2
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL alu_add_ctrl got=%b exp=00000", ctrl); end
        clock_model();
        set_dec(1, 5, 3, 6, 1, 1, 1, 0);                  // sub x6,x5,x3
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL alu_sub_nostall got=%b exp=00000", ctrl); end
        clock_model();
        set_dec(1, 6, 0, 9, 1, 0, 1, 0);                  // add x9,x6,x0
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin bad++; $display("FAIL alu_sub_sel got=%b exp=0100", {fwd_a_sel, fwd_b_sel}); end
        // memory wait with a jump pending: frozen, no flush
        mem_busy = 1'b1; exe_jump = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (ctrl !== 5'b11000) begin bad++; $display("FAIL freeze_ctrl[%0d] got=%b exp=11000", i, ctrl); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin bad++; $display("FAIL freeze_sel[%0d] got=%b exp=0100", i, {fwd_a_sel, fwd_b_sel}); end
            clock_model();
        end
        mem_busy = 1'b0;
        #1;
        total++; if (ctrl !== 5'b00011) begin bad++; $display("FAIL jump_flush got=%b exp=00011", ctrl); end
        clock_model();
        idle_inputs();
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL jump_squash_sel got=%b exp=0000", {fwd_a_sel, fwd_b_sel}); end
        total++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin bad++; $display("FAIL jump_cnt got=%0d/%0d exp=1/2", flush_cnt, stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1, 1, 0, 7, 1, 0, 1, 1);                  // lw x7,0(x1)
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL lu_lw_ctrl got=%b exp=00000", ctrl); end
        clock_model();
        set_dec(1, 7, 7, 8, 1, 1, 1, 0);                  // add x8,x7,x7
        #1;
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL lu_stall got=%b exp=11100", ctrl); end
        clock_model();
        exe_jump = 1'b1;                                  // EX holds the bubble: no redirect
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL lu_second_cycle got=%b exp=00000", ctrl); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        exe_jump = 1'b0;
        clock_model();
        idle_inputs();
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin bad++; $display("FAIL lu_fwd_mem got=%b exp=1010", {fwd_a_sel, fwd_b_sel}); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt_end got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        set_dec(1, 1, 0, 0, 1, 0, 1, 1);                  // lw x0,0(x1)
        clock_model();
        set_dec(1, 0, 0, 3, 1, 1, 1, 0);                  // add x3,x0,x0
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL x0_nostall got=%b exp=00000", ctrl); end
        clock_model();
        idle_inputs();
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL x0_sel got=%b exp=0000", {fwd_a_sel, fwd_b_sel}); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_dec(1, 1, 0, 7, 1, 0, 1, 1);                  // lw x7
        clock_model();
        set_dec(1, 7, 7, 8, 1, 1, 1, 0);                  // consumer
        exe_branch = 1'b1; br_true = 1'b1;
        #1;
        total++; if (ctrl !== 5'b00011) begin bad++; $display("FAIL br_flush got=%b exp=00011", ctrl); end
        clock_model();
        idle_inputs();
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL br_squash_sel got=%b exp=0000", {fwd_a_sel, fwd_b_sel}); end
        total++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin bad++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_wait_lu();
        do_reset();
        set_dec(1, 1, 0, 7, 1, 0, 1, 1);
        clock_model();
        set_dec(1, 7, 7, 8, 1, 1, 1, 0);
        #1;
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL mw_lu_stall got=%b exp=11100", ctrl); end
        clock_model();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctrl !== 5'b11000) begin bad++; $display("FAIL mw_ctrl[%0d] got=%b exp=11000", i, ctrl); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL mw_sel[%0d] got=%b exp=0000", i, {fwd_a_sel, fwd_b_sel}); end
            clock_model();
        end
        mem_busy = 1'b0;
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL mw_resume got=%b exp=00000", ctrl); end
        clock_model();
        idle_inputs();
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin bad++; $display("FAIL mw_fwd got=%b exp=1010", {fwd_a_sel, fwd_b_sel}); end
        total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL mw_stall_cnt got=%0d exp=4", stall_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_dec(1, 2, 0, 4, 1, 0, 1, 0);
        clock_model();
        set_dec(1, 4, 4, 5, 1, 1, 1, 0);
        mem_busy = 1'b1;
        clock_model();
        clock_model();
        total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL rmw_pre_cnt got=%0d exp=2", stall_cnt); end
        rst_n = 1'b0;
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL rmw_ctrl got=%b exp=00000", ctrl); end
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || {fwd_a_sel, fwd_b_sel} !== 4'b0) begin
            bad++; $display("FAIL rmw_regs got=%0d/%0d/%b exp=0/0/0000", stall_cnt, flush_cnt, {fwd_a_sel, fwd_b_sel});
        end
        mem_busy = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1;
        total++; if (ctrl !== 5'b0) begin bad++; $display("FAIL rmw_run got=%b exp=00000", ctrl); end
        clock_model();
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000 || stall_cnt !== 32'd0) begin
            bad++; $display("FAIL rmw_after got=%b/%0d exp=0000/0", {fwd_a_sel, fwd_b_sel}, stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rs1     = 5'($urandom_range(0, 3));
            dec_rs2     = 5'($urandom_range(0, 3));
            dec_rd      = 5'($urandom_range(0, 3));
            dec_use_rs1 = ($urandom_range(0, 3) != 0);
            dec_use_rs2 = ($urandom_range(0, 1) != 0);
            dec_wr      = ($urandom_range(0, 3) != 0);
            dec_load    = ($urandom_range(0, 2) == 0);
            exe_branch  = ($urandom_range(0, 5) == 0);
            exe_jump    = ($urandom_range(0, 11) == 0);
            br_true     = ($urandom_range(0, 1) != 0);
            mem_busy    = ($urandom_range(0, 4) == 0);
            #1;
            eval_model();
            total++; if (ctrl !== e_ctrl) begin bad++; $display("FAIL rnd_ctrl[%0d] got=%b exp=%b", n, ctrl, e_ctrl); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== {2'(m_fa), 2'(m_fb)}) begin
                bad++; $display("FAIL rnd_sel[%0d] got=%b exp=%b", n, {fwd_a_sel, fwd_b_sel}, {2'(m_fa), 2'(m_fb)});
            end
            total++; if (stall_cnt !== m_scnt) begin bad++; $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", n, stall_cnt, m_scnt); end
            total++; if (flush_cnt !== m_fcnt) begin bad++; $display("FAIL rnd_flush_cnt[%0d] got=%0d exp=%0d", n, flush_cnt, m_fcnt); end
            clock_model();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_x0();
        test_branch_flush();
        test_mem_wait_lu();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
